// File: rtl/rr_arbiter_x_in.sv
// Round-robin output-port arbiter: registered one-hot grant held until the
// holder releases or aborts, with a self-maintained rotating priority token.
module rr_arbiter_x_in #(
  parameter int IO_SIZE = 5,
  parameter int IO_w    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IO_SIZE-1:0] request,
  input  logic               release_in,
  output logic [IO_SIZE-1:0] grant,
  output logic [IO_w-1:0]    grant_id,
  output logic               grant_valid,
  output logic [IO_w-1:0]    token
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state_r, state_s;
  logic [IO_SIZE-1:0]   grant_r, grant_s;
  logic [IO_w-1:0]      grant_id_r, grant_id_s;
  logic                 grant_valid_r, grant_valid_s;
  logic [IO_w-1:0]      token_r, token_s;
  logic [IO_SIZE-1:0]   eligible_s;
  logic [IO_SIZE-1:0]   win_onehot_s;
  logic [IO_w:0]        pick_s;
  logic                 win_found_s;
  logic [IO_w-1:0]      win_idx_s;
  logic                 end_evt_s;

  // Circular scan from start; lowest offset wins. Returns {found, index}.
  function automatic logic [IO_w:0] rr_pick(input logic [IO_SIZE-1:0] req,
                                            input logic [IO_w-1:0]    start);
    logic [IO_w:0] res;
    int            j;
    res = '0;
    for (int k = IO_SIZE - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= IO_SIZE) j = j - IO_SIZE;
      else              j = j;
      if (req[j]) res = {1'b1, IO_w'(j)};
      else        res = res;
    end
    return res;
  endfunction

  // Index just past i, wrapping so the token never leaves 0..IO_SIZE-1.
  function automatic logic [IO_w-1:0] rr_next(input logic [IO_w-1:0] i);
    logic [IO_w-1:0] n;
    if (i == IO_w'(IO_SIZE - 1)) n = '0;
    else                         n = i + IO_w'(1);
    return n;
  endfunction

  // Eligible requests: the current holder is masked out of re-arbitration.
  always_comb begin
    eligible_s = request;
    for (int i = 0; i < IO_SIZE; i++) begin
      if (state_r == BUSY && IO_w'(i) == grant_id_r) eligible_s[i] = 1'b0;
      else                                           eligible_s[i] = request[i];
    end
  end

  assign pick_s      = rr_pick(eligible_s, token_r);
  assign win_found_s = pick_s[IO_w];
  assign win_idx_s   = pick_s[IO_w-1:0];
  assign end_evt_s   = release_in | ~request[grant_id_r];

  // One-hot decode of the arbitration winner.
  always_comb begin
    win_onehot_s = '0;
    for (int i = 0; i < IO_SIZE; i++) begin
      if (IO_w'(i) == win_idx_s) win_onehot_s[i] = 1'b1;
      else                       win_onehot_s[i] = 1'b0;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s       = state_r;
    grant_s       = grant_r;
    grant_id_s    = grant_id_r;
    grant_valid_s = grant_valid_r;
    token_s       = token_r;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          state_s       = BUSY;
          grant_s       = win_onehot_s;
          grant_id_s    = win_idx_s;
          grant_valid_s = 1'b1;
          token_s       = rr_next(win_idx_s);
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (end_evt_s) begin
          if (win_found_s) begin
            state_s       = BUSY;
            grant_s       = win_onehot_s;
            grant_id_s    = win_idx_s;
            grant_valid_s = 1'b1;
            token_s       = rr_next(win_idx_s);
          end else begin
            state_s       = IDLE;
            grant_s       = '0;
            grant_valid_s = 1'b0;
          end
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s       = IDLE;
        grant_s       = '0;
        grant_id_s    = '0;
        grant_valid_s = 1'b0;
        token_s       = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      grant_r       <= '0;
      grant_id_r    <= '0;
      grant_valid_r <= 1'b0;
      token_r       <= '0;
    end else begin
      state_r       <= state_s;
      grant_r       <= grant_s;
      grant_id_r    <= grant_id_s;
      grant_valid_r <= grant_valid_s;
      token_r       <= token_s;
    end
  end

  assign grant       = grant_r;
  assign grant_id    = grant_id_r;
  assign grant_valid = grant_valid_r;
  assign token       = token_r;

endmodule

// File: tb/tb_rr_arbiter_x_in.sv
// Self-checking bench for rr_arbiter_x_in: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_rr_arbiter_x_in;

  localparam int N  = 5;
  localparam int W  = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] request;
  logic         release_in;
  logic [N-1:0] grant;
  logic [W-1:0] grant_id;
  logic         grant_valid;
  logic [W-1:0] token;

  int errors = 0;
  int checks = 0;
  int gcount [N];

  // Behavioural model state.
  bit m_busy;
  int m_id;
  int m_tok;

  rr_arbiter_x_in #(.IO_SIZE(N), .IO_w(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .request     (request),
    .release_in  (release_in),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .token       (token)
  );

  always #5 clk = ~clk;

  function automatic int scan(input logic [N-1:0] req, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (j != excl && req[j]) return j;
    end
    return -1;
  endfunction

  // Reference model: round-robin rules applied on each rising edge.
  always @(posedge clk or negedge rst_n) begin : model
    int w;
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_id   <= 0;
      m_tok  <= 0;
    end else begin
      w = -1;
      if (!m_busy) begin
        w = scan(request, m_tok, -1);
      end else if (release_in || !request[m_id]) begin
        w = scan(request, m_tok, m_id);
        if (w < 0) m_busy <= 1'b0;
      end
      if (w >= 0) begin
        m_busy <= 1'b1;
        m_id   <= w;
        m_tok  <= (w + 1) % N;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    int exp_grant;
    exp_grant = m_busy ? (1 << m_id) : 0;
    chk("cyc_grant", int'(grant), exp_grant);
    chk("cyc_valid", int'(grant_valid), int'(m_busy));
    chk("cyc_id", int'(grant_id), m_id);
    chk("cyc_token", int'(token), m_tok);
    chk("cyc_inv", int'(grant_valid), int'(|grant));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string tag, input int g, input int id, input int v, input int t);
    chk({tag, "_grant"}, int'(grant), g);
    chk({tag, "_id"}, int'(grant_id), id);
    chk({tag, "_valid"}, int'(grant_valid), v);
    chk({tag, "_token"}, int'(token), t);
  endtask

  initial begin
    rst_n      = 1'b0;
    request    = '0;
    release_in = 1'b0;
    for (int i = 0; i < N; i++) gcount[i] = 0;
    tick();
    tick();
    rst_n = 1'b1;
    expect_out("reset", 0, 0, 0, 0);
    tick();
    tick();
    expect_out("idle_noreq", 0, 0, 0, 0);

    // Basic grant from token 0.
    request = 5'b10100;
    tick();
    expect_out("basic", 5'b00100, 2, 1, 3);

    // Hold while other requests change.
    request = 5'b10101;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("hold_grant", int'(grant), 5'b00100);
      chk("hold_token", int'(token), 3);
    end

    // Back-to-back with wrap.
    release_in = 1'b1;
    tick();
    expect_out("b2b_wrap", 5'b10000, 4, 1, 0);
    request = 5'b00001;
    tick();
    expect_out("b2b_second", 5'b00001, 0, 1, 1);

    // Abort to idle, then simultaneous release and abort.
    release_in = 1'b0;
    request    = 5'b00000;
    tick();
    expect_out("abort", 0, 0, 0, 1);
    request = 5'b00001;
    tick();
    expect_out("regrant0", 5'b00001, 0, 1, 1);
    request    = 5'b00000;
    release_in = 1'b1;
    tick();
    expect_out("rel_abort", 0, 0, 0, 1);

    // Fairness: all request, release every cycle.
    request = 5'b11111;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("fair_id", int'(grant_id), (k + 1) % N);
      chk("fair_valid", int'(grant_valid), 1);
      gcount[grant_id]++;
    end
    for (int i = 0; i < N; i++) chk("fair_count", gcount[i], 2);

    // Asynchronous reset mid-BUSY, between clock edges.
    release_in = 1'b0;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 0, 0);
    request = 5'b00000;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    expect_out("post_rst", 0, 0, 0, 0);

    // Randomized traffic checked by the per-cycle comparison.
    for (int c = 0; c < 3000; c++) begin
      request    = N'($urandom_range(0, (1 << N) - 1) & $urandom_range(0, (1 << N) - 1));
      release_in = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) request = '1;
      tick();
    end
    request    = '0;
    release_in = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_x_in.md
# rr_arbiter_x_in

Round-robin arbiter for one router output port. It takes the per-input request vector, issues a registered one-hot grant, and holds that grant until the winning input signals end of packet. It keeps its own priority token: after every grant, the token moves to the index just past the winner, wrapping at IO_SIZE-1. It is the consumer-side partner of the token-update logic in the rr_x_in arbitration path, and sits between the input-port request generators and the output-port crossbar select.

## Interface
- IO_SIZE, 5, number of requesting inputs; must be ≥ 1.
- IO_w, 3, width of an index; ceil(log2(IO_SIZE)), minimum 1.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- request  input  IO_SIZE  per-input request; bit i high means input i wants the port.
- release_in  input  1  the current holder finishes its packet this cycle (tail flit accepted).
- grant  output  IO_SIZE  registered one-hot grant; all zeros when no grant is held.
- grant_id  output  IO_w  binary index of the granted input; valid only while grant_valid is high.
- grant_valid  output  1  high while any grant is held; equals |grant.
- token  output  IO_w  current priority pointer, for debug and coverage.

## Operation
- Reset (rst_n low) takes effect immediately, with no clock needed:
  - grant=0, grant_id=0, grant_valid=0, token=0, state IDLE.
- States:
  - IDLE: no grant is held.
  - BUSY: one grant is held.
- Arbitration function (combinational):
  - Scan request circularly, starting at index token: token, token+1, …, IO_SIZE-1, 0, …, token-1.
  - The winner is the first index with its request bit set.
  - No request means no winner.
- IDLE:
  - If a winner exists: on the next edge, grant=onehot(winner), grant_id=winner, grant_valid=1, token=next(winner), go to BUSY.
  - Otherwise stay in IDLE with outputs unchanged.
- next(i) = 0 if i==IO_SIZE-1, else i+1.
  - token is always in 0..IO_SIZE-1 and is never loaded with an out-of-range value.
- BUSY: the grant is held unchanged while release_in=0 and request[grant_id]=1.
  - Changes to other request bits are ignored while a grant is held.
- End of grant occurs when release_in=1, or when request[grant_id]=0 (requester abort). Both at once count as a single end event.
  - If a winner exists among the current request bits, re-grant on the same edge with no bubble. Update token to next(new winner) and stay in BUSY.
  - The releasing input is excluded from that re-arbitration. It can win again only on a later cycle.
  - If no eligible winner exists: on the next edge, grant=0, grant_valid=0, grant_id unchanged, go to IDLE. token is unchanged.
- In IDLE, release_in is ignored.
- The token advances only when a grant is issued, never on a release alone.
- With IO_SIZE=1, the token stays 0. A request is granted in 1 cycle and held until released.
- Invariant: grant is one-hot or zero, and grant_valid == |grant at all times.

## Timing
- Request to grant: 1 cycle. A request sampled at edge N gives grant visible after edge N.
- Release to next grant: 0 bubble cycles. The new grant is visible the cycle after release_in is sampled.
- Release to idle: grant drops the cycle after release_in is sampled.
- All outputs are registered; there are no combinational paths from request or release_in to any output.
- Reset assertion mid-BUSY clears grant asynchronously.
- After rst_n deasserts, the first arbitration happens at the first rising edge where rst_n is high.

## Test plan
- Reset: drive rst_n=0 mid-BUSY with no clock edge -> grant=00000, grant_valid=0, token=0 immediately. Release rst_n with request=00000 -> outputs stay 0.
- Basic grant: from IDLE with token=0, request=10100 -> next cycle grant=00100, grant_id=2, token=3.
- Hold: while holding grant=00100, change request to 10101 for 8 cycles with release_in=0 and request[2]=1 -> grant stays 00100 and token stays 3.
- Back-to-back with wrap: holder 2, token 3, request=10101, release_in=1 -> next cycle grant=10000, id=4, token=0. Release again with request=00001 -> grant=00001, id=0, token=1, no idle cycle between grants.
- Abort and idle: holder 0; request[0] drops to 0 with release_in=0 and no other requests -> next cycle grant=00000, grant_valid=0, token=1. Simultaneous release_in=1 with request[0]=0 behaves identically.
- Fairness: hold request=11111, pulse release_in every cycle for 10 grants -> grant_id sequence 1,2,3,4,0,1,2,3,4,0. Each input is granted exactly twice.
